// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the clk5 reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request inputs and sequenced reset outputs of reset_sequencer.
interface reset_sequencer_if #(
  parameter int N_OUT = 3
);
  logic             btnN;
  logic             swReq;
  logic [N_OUT-1:0] rstOut;
  logic             ready;
  logic [1:0]       rstCause;

  modport master (output btnN, output swReq, input rstOut, input ready, input rstCause);
  modport slave  (input btnN, input swReq, output rstOut, output ready, output rstCause);
endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// Flop chain with async set to all ones; SHIFT_ZERO feeds a constant 0 instead of i_d.
module sync_chain #(
  parameter int STAGES     = 2,
  parameter bit SHIFT_ZERO = 1'b0
) (
  input  logic clk5,
  input  logic i_set,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  logic              w_in;

  assign w_in = SHIFT_ZERO ? 1'b0 : i_d;

  always_ff @(posedge clk5 or posedge i_set) begin
    if (i_set) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], w_in};
    end
  end

  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator for the clk5 domain: hold, then staggered release in index order.
// Optional RSTSEQ_DEBOUNCE_EN qualifies the pushbutton with a consecutive-low debounce.
//   state   | meaning
//   HOLD    | all outputs asserted, counting the hold time
//   RELEASE | bit 0 released, releasing idx every STAGGER cycles
//   RUN     | all outputs released, waiting for a request
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_OUT           = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk5,
  input  logic             resetIn,
  reset_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STAGGER) + 1);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CNT_W-1:0] HOLD_T   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STAG_T   = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

  if (N_OUT < 1 || N_OUT > 8) begin : g_chk_n_out
    $error("reset_sequencer: N_OUT must be in 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER < 1) begin : g_chk_stagger
    $error("reset_sequencer: STAGGER must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("reset_sequencer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             w_int_rst;
  logic             w_btn_sync;
  logic             w_btn_press;
  logic             w_req;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N_OUT-1:0] r_rst_out, w_rst_nxt;
  logic             r_ready, w_ready_nxt;
  logic [1:0]       r_cause, w_cause_nxt;

  // Release of resetIn only reaches the FSM through this chain; assertion is immediate via the set.
  sync_chain #(.STAGES(SYNC_STAGES), .SHIFT_ZERO(1'b1)) u_rst_sync (
    .clk5  (clk5),
    .i_set (resetIn),
    .i_d   (1'b0),
    .o_q   (w_int_rst)
  );

  sync_chain #(.STAGES(SYNC_STAGES), .SHIFT_ZERO(1'b0)) u_btn_sync (
    .clk5  (clk5),
    .i_set (resetIn),
    .i_d   (bus.btnN),
    .o_q   (w_btn_sync)
  );

`ifdef RSTSEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_press;

  always_ff @(posedge clk5 or posedge resetIn) begin
    if (resetIn) begin
      r_db_cnt    <= '0;
      r_btn_press <= 1'b0;
    end else if (w_btn_sync) begin
      r_db_cnt    <= '0;
      r_btn_press <= 1'b0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_btn_press <= 1'b1;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_btn_press = r_btn_press;
`else
  assign w_btn_press = ~w_btn_sync;
`endif

  // A held button re-requests every edge, which keeps the hold counter pinned at 0.
  assign w_req = w_btn_press | bus.swReq;

  always_ff @(posedge clk5 or posedge w_int_rst) begin
    if (w_int_rst) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_cause   <= CAUSE_POR;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_nxt;
      r_ready   <= w_ready_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    if (w_req) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_cnt == HOLD_T) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = (N_OUT == 1) ? RUN : RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == STAG_T) begin
            w_cnt_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = RUN;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_rst_nxt   = r_rst_out;
    w_ready_nxt = r_ready;
    w_cause_nxt = r_cause;
    if (w_req) begin
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      w_cause_nxt = w_btn_press ? CAUSE_BTN : CAUSE_SW;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_cnt == HOLD_T) begin
            w_rst_nxt[0] = 1'b0;
            if (N_OUT == 1) begin
              w_ready_nxt = 1'b1;
            end
          end
        end
        RELEASE: begin
          if (r_cnt == STAG_T) begin
            for (int i = 0; i < N_OUT; i++) begin
              if (r_idx == IDX_W'(i)) begin
                w_rst_nxt[i] = 1'b0;
              end
            end
            if (r_idx == IDX_LAST) begin
              w_ready_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_ready_nxt = r_ready;
        end
      endcase
    end
  end

  assign bus.rstOut   = r_rst_out;
  assign bus.ready    = r_ready;
  assign bus.rstCause = r_cause;
endmodule
